// File: rtl/qsp_alu_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qspa_pkg / qsp_alu_arb_if / qsp_alu_rsp_if                            |
// | Shared types plus requester and response channels of the ALU arbiter. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package qspa_pkg;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ADD_REG = 3'd0,
        ADD_IMM = 3'd1,
        SUB_REG = 3'd2,
        AND_REG = 3'd3,
        OR_REG  = 3'd4,
        XOR_REG = 3'd5,
        CMP_IMM = 3'd6,
        LCSET   = 3'd7
    } op_t;
endpackage

interface qsp_alu_arb_if #(
    parameter int DATA_WIDTH = qspa_pkg::DATA_WIDTH
);
    logic                  valid;
    qspa_pkg::op_t         op;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic                  ready;

    modport master (output valid, op, op1, op2, input ready);
    modport slave  (input valid, op, op1, op2, output ready);
endinterface

interface qsp_alu_rsp_if #(
    parameter int DATA_WIDTH = qspa_pkg::DATA_WIDTH
);
    logic                  valid;
    logic                  id;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
    logic                  ovf;
    logic                  ready;

    modport master (output valid, id, result, zero, carry, ovf, input ready);
    modport slave  (input valid, id, result, zero, carry, ovf, output ready);
endinterface
`default_nettype wire

// File: rtl/qsp_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qsp_alu_arb                                                           |
// | Round-robin arbiter sharing one combinational ALU between two         |
// | requesters, with a single registered response slot.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module qsp_alu_arb #(
    parameter int DATA_WIDTH = qspa_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qsp_alu_arb_if.slave          req0,
    qsp_alu_arb_if.slave          req1,
    qsp_alu_rsp_if.master         rsp,
    output qspa_pkg::op_t         alu_op,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_ovf,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  w_can_issue;
    logic                  w_cand;
    logic                  w_accept;
    logic [1:0]            w_acc_vec;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_carry;
    logic                  r_rsp_ovf;
    logic [CNT_WIDTH-1:0]  r_cnt [2];

    // Readiness is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_can_issue = rst_n && ((r_state == S_IDLE) || rsp.ready);
        w_cand      = (req0.valid && req1.valid) ? ~r_last_grant : req1.valid;
        req0.ready  = w_can_issue && req0.valid && !w_cand;
        req1.ready  = w_can_issue && req1.valid && w_cand;
        w_accept    = req0.ready || req1.ready;
        w_acc_vec   = {req1.ready, req0.ready};
        if (w_accept) begin
            w_state_nxt = S_RESP;
        end else if ((r_state == S_RESP) && rsp.ready) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign alu_op  = w_cand ? req1.op  : req0.op;
    assign alu_op1 = w_cand ? req1.op1 : req0.op1;
    assign alu_op2 = w_cand ? req1.op2 : req0.op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_cand;
            r_rsp_id     <= w_cand;
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_carry  <= alu_carry;
            r_rsp_ovf    <= alu_ovf;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[gi] <= '0;
            end else if (w_acc_vec[gi] && (r_cnt[gi] != {CNT_WIDTH{1'b1}})) begin
                r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    end

    assign grant_cnt0 = r_cnt[0];
    assign grant_cnt1 = r_cnt[1];

    assign rsp.valid  = (r_state == S_RESP);
    assign rsp.id     = r_rsp_id;
    assign rsp.result = r_rsp_result;
    assign rsp.zero   = r_rsp_zero;
    assign rsp.carry  = r_rsp_carry;
    assign rsp.ovf    = r_rsp_ovf;

endmodule
`default_nettype wire

// File: tb/tb_qsp_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qsp_alu_arb                                                        |
// | Table vectors, corner sequences and random traffic vs a transaction   |
// | model. Revision: 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_qsp_alu_arb;
    import qspa_pkg::*;

    localparam int DW   = qspa_pkg::DATA_WIDTH;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] r;
        logic          z;
        logic          c;
        logic          o;
    } alu_res_t;

    typedef struct {
        bit            rst;
        bit            v0, v1, rr;
        op_t           o0;
        logic [DW-1:0] a0, b0;
        op_t           o1;
        logic [DW-1:0] a1, b1;
        bit            e_r0, e_r1, e_val, e_id;
        logic [DW-1:0] e_res;
        bit            e_z;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qsp_alu_arb_if #(.DATA_WIDTH(DW)) req0_if ();
    qsp_alu_arb_if #(.DATA_WIDTH(DW)) req1_if ();
    qsp_alu_rsp_if #(.DATA_WIDTH(DW)) rsp_if ();

    op_t           alu_op;
    logic [DW-1:0] alu_op1, alu_op2, alu_result;
    logic          alu_zero, alu_carry, alu_ovf;
    logic [CW-1:0] grant_cnt0, grant_cnt1;
    alu_res_t      alu_w;

    qsp_alu_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0_if.slave),
        .req1       (req1_if.slave),
        .rsp        (rsp_if.master),
        .alu_op     (alu_op),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    function automatic alu_res_t alu_f(op_t op, logic [DW-1:0] a, logic [DW-1:0] b);
        alu_res_t   o;
        logic [DW:0] t;
        o = '0;
        t = '0;
        case (op)
            ADD_REG, ADD_IMM: begin
                t   = {1'b0, a} + {1'b0, b};
                o.r = t[DW-1:0];
                o.c = t[DW];
                o.o = (a[DW-1] == b[DW-1]) && (o.r[DW-1] != a[DW-1]);
            end
            SUB_REG, CMP_IMM: begin
                t   = {1'b0, a} - {1'b0, b};
                o.r = t[DW-1:0];
                o.c = t[DW];
                o.o = (a[DW-1] != b[DW-1]) && (o.r[DW-1] != a[DW-1]);
            end
            AND_REG: o.r = a & b;
            OR_REG:  o.r = a | b;
            XOR_REG: o.r = a ^ b;
            LCSET:   o.r = (a < b) ? DW'(1) : '0;
            default: o.r = '0;
        endcase
        o.z = (o.r == '0);
        return o;
    endfunction

    assign alu_w      = alu_f(alu_op, alu_op1, alu_op2);
    assign alu_result = alu_w.r;
    assign alu_zero   = alu_w.z;
    assign alu_carry  = alu_w.c;
    assign alu_ovf    = alu_w.o;

    int       errors = 0;
    int       checks = 0;
    // Transaction-level model: one held response slot and per-requester tallies.
    bit       m_held;
    int       m_id;
    int       m_last;
    alu_res_t m_rsp;
    int       m_cnt [2];
    bit       obs_r0, obs_r1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_id   = 0;
        m_last = 1;
        m_rsp  = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic check_rsp();
        chk("rsp_valid",  int'(rsp_if.valid),  int'(m_held));
        chk("rsp_id",     int'(rsp_if.id),     m_id);
        chk("rsp_result", int'(rsp_if.result), int'(m_rsp.r));
        chk("rsp_zero",   int'(rsp_if.zero),   int'(m_rsp.z));
        chk("rsp_carry",  int'(rsp_if.carry),  int'(m_rsp.c));
        chk("rsp_ovf",    int'(rsp_if.ovf),    int'(m_rsp.o));
        chk("grant_cnt0", int'(grant_cnt0),    m_cnt[0]);
        chk("grant_cnt1", int'(grant_cnt1),    m_cnt[1]);
    endtask

    task automatic drive(input bit v0, input bit v1, input bit rr,
                         input op_t o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input op_t o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        req0_if.valid = v0; req0_if.op = o0; req0_if.op1 = a0; req0_if.op2 = b0;
        req1_if.valid = v1; req1_if.op = o1; req1_if.op1 = a1; req1_if.op2 = b1;
        rsp_if.ready  = rr;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1 with outputs checked.
    task automatic run_cycle(input bit v0, input bit v1, input bit rr,
                             input op_t o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                             input op_t o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        int g;
        drive(v0, v1, rr, o0, a0, b0, o1, a1, b1);
        #1;
        g = -1;
        if (!m_held || rr) begin
            if (v0 && v1) g = 1 - m_last;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        obs_r0 = req0_if.ready;
        obs_r1 = req1_if.ready;
        chk("req0_ready", int'(obs_r0), int'(g == 0));
        chk("req1_ready", int'(obs_r1), int'(g == 1));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_held = 1'b1;
            m_id   = g;
            m_rsp  = (g == 0) ? alu_f(o0, a0, b0) : alu_f(o1, a1, b1);
            m_last = g;
            if (m_cnt[g] < CMAX) m_cnt[g]++;
        end else if (m_held && rr) begin
            m_held = 1'b0;
        end
        check_rsp();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, ADD_REG, '0, '0, ADD_REG, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("reset_req0_ready", int'(req0_if.ready), 0);
        chk("reset_req1_ready", int'(req1_if.ready), 0);
        model_reset();
        check_rsp();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_opnd();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
        return DW'($urandom());
    endfunction

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 1, 0, 1, ADD_REG, 5,  7,  ADD_REG, 0,  0,  1, 0, 1, 0, 12, 0};
        tbl[1]  = '{1, 1, 1, 1, ADD_REG, 1,  2,  ADD_REG, 10, 20, 1, 0, 1, 0, 3,  0};
        tbl[2]  = '{0, 1, 1, 1, ADD_REG, 1,  2,  ADD_REG, 10, 20, 0, 1, 1, 1, 30, 0};
        tbl[3]  = '{0, 1, 1, 1, ADD_REG, 1,  2,  ADD_REG, 10, 20, 1, 0, 1, 0, 3,  0};
        tbl[4]  = '{0, 1, 1, 1, ADD_REG, 1,  2,  ADD_REG, 10, 20, 0, 1, 1, 1, 30, 0};
        tbl[5]  = '{0, 0, 1, 0, ADD_REG, 0,  0,  SUB_REG, 9,  4,  0, 0, 1, 1, 30, 0};
        tbl[6]  = '{0, 0, 1, 0, ADD_REG, 0,  0,  SUB_REG, 9,  4,  0, 0, 1, 1, 30, 0};
        tbl[7]  = '{0, 0, 1, 0, ADD_REG, 0,  0,  SUB_REG, 9,  4,  0, 0, 1, 1, 30, 0};
        tbl[8]  = '{0, 0, 1, 1, ADD_REG, 0,  0,  SUB_REG, 9,  4,  0, 1, 1, 1, 5,  0};
        tbl[9]  = '{0, 1, 0, 1, SUB_REG, 3,  3,  ADD_REG, 0,  0,  1, 0, 1, 0, 0,  1};
        tbl[10] = '{0, 1, 0, 1, CMP_IMM, 3,  3,  ADD_REG, 0,  0,  1, 0, 1, 0, 0,  1};
        tbl[11] = '{0, 0, 0, 1, ADD_REG, 0,  0,  ADD_REG, 0,  0,  0, 0, 0, 0, 0,  0};

        model_reset();
        drive(1'b0, 1'b0, 1'b0, ADD_REG, '0, '0, ADD_REG, '0, '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            run_cycle(tbl[i].v0, tbl[i].v1, tbl[i].rr, tbl[i].o0, tbl[i].a0, tbl[i].b0,
                      tbl[i].o1, tbl[i].a1, tbl[i].b1);
            chk($sformatf("tbl%0d_req0_ready", i), int'(obs_r0), int'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_req1_ready", i), int'(obs_r1), int'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_rsp_valid", i), int'(rsp_if.valid), int'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_rsp_id", i), int'(rsp_if.id), int'(tbl[i].e_id));
                chk($sformatf("tbl%0d_rsp_result", i), int'(rsp_if.result), int'(tbl[i].e_res));
                chk($sformatf("tbl%0d_rsp_zero", i), int'(rsp_if.zero), int'(tbl[i].e_z));
            end
            if (i == 0) chk("tbl0_grant_cnt0", int'(grant_cnt0), 1);
            if (i == 4) begin
                chk("rr_grant_cnt0", int'(grant_cnt0), 2);
                chk("rr_grant_cnt1", int'(grant_cnt1), 2);
            end
        end

        // Asynchronous reset in the middle of a held response.
        run_cycle(1'b1, 1'b0, 1'b1, ADD_REG, 16'd4, 16'd4, ADD_REG, '0, '0);
        drive(1'b1, 1'b1, 1'b0, ADD_REG, '0, '0, ADD_REG, '0, '0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rsp_valid", int'(rsp_if.valid), 0);
        chk("async_rst_cnt0", int'(grant_cnt0), 0);
        chk("async_rst_cnt1", int'(grant_cnt1), 0);
        chk("async_rst_req0_ready", int'(req0_if.ready), 0);
        chk("async_rst_req1_ready", int'(req1_if.ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(1'b1, 1'b1, 1'b1, XOR_REG, 16'h00ff, 16'h0f0f, OR_REG, 16'h1, 16'h2);
        chk("post_rst_grant_req0", int'(obs_r0), 1);
        chk("post_rst_rsp_id", int'(rsp_if.id), 0);

        // Counter saturation at all-ones.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1, LCSET, DW'(i), 16'd10, ADD_REG, '0, '0);
        end
        chk("cnt0_saturated", int'(grant_cnt0), CMAX);
        chk("cnt1_untouched", int'(grant_cnt1), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) < 7),
                      op_t'(3'($urandom_range(0, 7))), rnd_opnd(), rnd_opnd(),
                      op_t'(3'($urandom_range(0, 7))), rnd_opnd(), rnd_opnd());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
